// File: rtl/proc_pkg.sv
// Shared datapath definitions: sequencer state encoding and the address-update
// operation codes chosen by the command priority mux.
package proc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LD   = 3'd1,
      OP_ADD  = 3'd2,
      OP_INC  = 3'd3,
      OP_DEC  = 3'd4
   } op_e;

endpackage

// File: rtl/addr_alu_sat.sv
// Combinational WIDTH+1-bit add/subtract used for every address update,
// flagging carry/borrow and optionally clamping to the address range.
module addr_alu_sat #(
   parameter int WIDTH    = 16,
   parameter int SAT_MODE = 0
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] operand_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] next_o,
   output logic             ovf_evt_o
);

   logic [WIDTH:0] sum;

   // The extra top bit is the carry on add and the borrow on subtract.
   always_comb begin
      if (sub_i) begin
         sum = {1'b0, cur_i} - {1'b0, operand_i};
      end else begin
         sum = {1'b0, cur_i} + {1'b0, operand_i};
      end
      ovf_evt_o = sum[WIDTH];
      next_o    = sum[WIDTH-1:0];
      if ((SAT_MODE != 0) && sum[WIDTH]) begin
         next_o = sub_i ? '0 : '1;
      end
   end

endmodule

// File: rtl/addr_reg_seq.sv
// Address register with load/inc/dec/signed-offset updates, sticky overflow,
// and a req/ack memory-access sequencer with optional post-increment.
module addr_reg_seq
   import proc_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0,
   parameter int SAT_MODE  = 0
) (
   input  logic             clk_i,
   input  logic             rst_b_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] ld_val_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             add_off_i,
   input  logic [WIDTH-1:0] off_i,
   input  logic             acc_start_i,
   input  logic             post_inc_i,
   input  logic             mem_ack_i,
   input  logic             ovf_clr_i,
   output logic [WIDTH-1:0] out_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic             mem_req_o,
   output logic             busy_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic             post_inc_q, post_inc_d;
   logic             ovf_q, ovf_d;

   op_e              op;
   logic [WIDTH-1:0] aluOperand;
   logic             aluSub;
   logic [WIDTH-1:0] aluNext;
   logic             aluOvf;

   addr_alu_sat #(
      .WIDTH    (WIDTH),
      .SAT_MODE (SAT_MODE)
   ) u_alu (
      .cur_i     (out_q),
      .operand_i (aluOperand),
      .sub_i     (aluSub),
      .next_o    (aluNext),
      .ovf_evt_o (aluOvf)
   );

   // Commands only act in IDLE without acc_start; in REQ the sole update is the
   // post-increment on ack, which reuses the INC path through the ALU.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      post_inc_d = post_inc_q;
      op         = OP_NONE;
      case (state_q)
         ST_IDLE: begin
            if (acc_start_i) begin
               state_d    = ST_REQ;
               mem_addr_d = out_q;
               post_inc_d = post_inc_i;
            end else if (ld_i) begin
               op = OP_LD;
            end else if (add_off_i) begin
               op = OP_ADD;
            end else if (inc_i && !dec_i) begin
               op = OP_INC;
            end else if (dec_i && !inc_i) begin
               op = OP_DEC;
            end
         end
         ST_REQ: begin
            if (mem_ack_i) begin
               state_d    = ST_IDLE;
               post_inc_d = 1'b0;
               if (post_inc_q) begin
                  op = OP_INC;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A negative offset becomes a subtraction of its magnitude so that the
   // borrow out of the unsigned address range is the underflow condition.
   always_comb begin
      aluOperand = STEP_W;
      aluSub     = 1'b0;
      case (op)
         OP_ADD: begin
            if (off_i[WIDTH-1]) begin
               aluOperand = -off_i;
               aluSub     = 1'b1;
            end else begin
               aluOperand = off_i;
            end
         end
         OP_DEC:  aluSub = 1'b1;
         default: aluSub = 1'b0;
      endcase
   end

   // A new overflow event beats a same-cycle clear so no event is lost.
   always_comb begin
      out_d = out_q;
      ovf_d = ovf_q;
      case (op)
         OP_LD:                 out_d = ld_val_i;
         OP_ADD, OP_INC, OP_DEC: out_d = aluNext;
         default:               out_d = out_q;
      endcase
      if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
      if (aluOvf && (op == OP_ADD || op == OP_INC || op == OP_DEC)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_b_i) begin
      if (rst_b_i) begin
         state_q    <= ST_IDLE;
         out_q      <= RESET_W;
         mem_addr_q <= '0;
         post_inc_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         mem_addr_q <= mem_addr_d;
         post_inc_q <= post_inc_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_o      = out_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_req_o  = (state_q == ST_REQ);
   assign busy_o     = mem_req_o;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_addr_reg_seq.sv
// Directed bench for addr_reg_seq: a wrapping and a saturating instance share
// stimulus; expected values are queued before each step and popped on check.
module tb_addr_reg_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld = 1'b0, inc = 1'b0, dec = 1'b0, addOff = 1'b0;
   logic        accStart = 1'b0, postInc = 1'b0, memAck = 1'b0, ovfClr = 1'b0;
   logic [15:0] val = '0;

   logic [15:0] outW, memAddrW, outS, memAddrS;
   logic        memReqW, busyW, ovfW, memReqS, busyS, ovfS;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;
   exp_t sbQ[$];

   always #5 clk = ~clk;

   addr_reg_seq #(.WIDTH(16), .STEP(1), .RESET_VAL(0), .SAT_MODE(0)) dutW (
      .clk_i(clk), .rst_b_i(rst), .ld_i(ld), .ld_val_i(val), .inc_i(inc),
      .dec_i(dec), .add_off_i(addOff), .off_i(val), .acc_start_i(accStart),
      .post_inc_i(postInc), .mem_ack_i(memAck), .ovf_clr_i(ovfClr),
      .out_o(outW), .mem_addr_o(memAddrW), .mem_req_o(memReqW),
      .busy_o(busyW), .ovf_o(ovfW)
   );

   addr_reg_seq #(.WIDTH(16), .STEP(1), .RESET_VAL(0), .SAT_MODE(1)) dutS (
      .clk_i(clk), .rst_b_i(rst), .ld_i(ld), .ld_val_i(val), .inc_i(inc),
      .dec_i(dec), .add_off_i(addOff), .off_i(val), .acc_start_i(accStart),
      .post_inc_i(postInc), .mem_ack_i(memAck), .ovf_clr_i(ovfClr),
      .out_o(outS), .mem_addr_o(memAddrS), .mem_req_o(memReqS),
      .busy_o(busyS), .ovf_o(ovfS)
   );

   task automatic pushExp(input string tag, input logic [15:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sbQ.push_back(x);
   endtask

   // Drives one cycle of commands, then clears them and samples 1 ns after the edge.
   task automatic applyStimulus(input logic ldI, input logic addI, input logic incI,
                                input logic decI, input logic accI, input logic postI,
                                input logic ackI, input logic clrI, input logic [15:0] valI);
      ld = ldI; addOff = addI; inc = incI; dec = decI;
      accStart = accI; postInc = postI; memAck = ackI; ovfClr = clrI; val = valI;
      @(posedge clk);
      #1;
      ld = 1'b0; addOff = 1'b0; inc = 1'b0; dec = 1'b0;
      accStart = 1'b0; postInc = 1'b0; memAck = 1'b0; ovfClr = 1'b0;
   endtask

   task automatic checkOutput(input logic [15:0] obs);
      exp_t x;
      nChecks++;
      if (sbQ.size() == 0) begin
         nFail++;
         $display("[TB] FAIL scoreboard_empty: observed %h required an expectation", obs);
      end else begin
         x = sbQ.pop_front();
         assert (obs === x.exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
         end
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      pushExp("rst_out", 16'h0000);   checkOutput(outW);
      pushExp("rst_addr", 16'h0000);  checkOutput(memAddrW);
      pushExp("rst_req", 16'h0);      checkOutput({15'b0, memReqW});
      pushExp("rst_busy", 16'h0);     checkOutput({15'b0, busyW});
      pushExp("rst_ovf", 16'h0);      checkOutput({15'b0, ovfW});
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: load, increment, inc+dec cancel
      pushExp("ld_1234", 16'h1234);
      applyStimulus(1,0,0,0,0,0,0,0,16'h1234); checkOutput(outW);
      pushExp("inc_1235", 16'h1235);
      applyStimulus(0,0,1,0,0,0,0,0,16'h0000); checkOutput(outW);
      pushExp("incdec_out", 16'h1235);
      pushExp("incdec_ovf", 16'h0);
      applyStimulus(0,0,1,1,0,0,0,0,16'h0000); checkOutput(outW); checkOutput({15'b0, ovfW});

      // 2: overflow on inc, wrap vs saturate, then clear
      applyStimulus(1,0,0,0,0,0,0,0,16'hFFFF);
      pushExp("wrap_out", 16'h0000);  pushExp("wrap_ovf", 16'h1);
      pushExp("sat_out", 16'hFFFF);   pushExp("sat_ovf", 16'h1);
      applyStimulus(0,0,1,0,0,0,0,0,16'h0000);
      checkOutput(outW); checkOutput({15'b0, ovfW}); checkOutput(outS); checkOutput({15'b0, ovfS});
      pushExp("clr_ovfW", 16'h0);     pushExp("clr_ovfS", 16'h0);
      applyStimulus(0,0,0,0,0,0,0,1,16'h0000);
      checkOutput({15'b0, ovfW}); checkOutput({15'b0, ovfS});

      // dec underflow
      applyStimulus(1,0,0,0,0,0,0,0,16'h0000);
      pushExp("dec_wrap", 16'hFFFF);  pushExp("dec_sat", 16'h0000); pushExp("dec_ovf", 16'h1);
      applyStimulus(0,0,0,1,0,0,0,0,16'h0000);
      checkOutput(outW); checkOutput(outS); checkOutput({15'b0, ovfS});
      applyStimulus(0,0,0,0,0,0,0,1,16'h0000);

      // 3: signed offset -2
      applyStimulus(1,0,0,0,0,0,0,0,16'h0010);
      pushExp("off_neg_out", 16'h000E); pushExp("off_neg_ovf", 16'h0);
      applyStimulus(0,1,0,0,0,0,0,0,16'hFFFE);
      checkOutput(outW); checkOutput({15'b0, ovfW});
      applyStimulus(1,0,0,0,0,0,0,0,16'h0001);
      pushExp("off_under_wrap", 16'hFFFF); pushExp("off_under_ovf", 16'h1);
      pushExp("off_under_sat", 16'h0000);
      applyStimulus(0,1,0,0,0,0,0,0,16'hFFFE);
      checkOutput(outW); checkOutput({15'b0, ovfW}); checkOutput(outS);
      applyStimulus(0,0,0,0,0,0,0,1,16'h0000);
      applyStimulus(1,0,0,0,0,0,0,0,16'hFFF0);
      pushExp("off_pos_wrap", 16'h0010); pushExp("off_pos_sat", 16'hFFFF);
      pushExp("off_pos_ovf", 16'h1);
      applyStimulus(0,1,0,0,0,0,0,0,16'h0020);
      checkOutput(outW); checkOutput(outS); checkOutput({15'b0, ovfW});
      applyStimulus(0,0,0,0,0,0,0,1,16'h0000);

      // 4: access with post-increment, ack after three REQ cycles
      applyStimulus(1,0,0,0,0,0,0,0,16'h0100);
      pushExp("acc_req1", 16'h1);     pushExp("acc_addr1", 16'h0100);
      applyStimulus(0,0,0,0,1,1,0,0,16'h0000);
      checkOutput({15'b0, memReqW}); checkOutput(memAddrW);
      pushExp("req_ld_out", 16'h0100); pushExp("acc_req2", 16'h1);
      applyStimulus(1,0,0,0,0,0,0,0,16'hAAAA);
      checkOutput(outW); checkOutput({15'b0, memReqW});
      pushExp("acc_req3", 16'h1);     pushExp("acc_addr3", 16'h0100); pushExp("acc_busy3", 16'h1);
      applyStimulus(0,0,1,0,1,0,0,0,16'h0000);
      checkOutput({15'b0, memReqW}); checkOutput(memAddrW); checkOutput({15'b0, busyW});
      pushExp("ack_out", 16'h0101);   pushExp("ack_busy", 16'h0); pushExp("ack_req", 16'h0);
      applyStimulus(0,0,0,0,0,0,1,0,16'h0000);
      checkOutput(outW); checkOutput({15'b0, busyW}); checkOutput({15'b0, memReqW});

      // 5: asynchronous reset in the middle of a post-incrementing access
      applyStimulus(1,0,0,0,0,0,0,0,16'h0200);
      applyStimulus(0,0,0,0,1,1,0,0,16'h0000);
      #2 rst = 1'b1;
      #1;
      pushExp("arst_req", 16'h0);     pushExp("arst_out", 16'h0000); pushExp("arst_busy", 16'h0);
      checkOutput({15'b0, memReqW}); checkOutput(outW); checkOutput({15'b0, busyW});
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      pushExp("idle_ack_out", 16'h0000); pushExp("idle_ack_req", 16'h0);
      applyStimulus(0,0,0,0,0,0,1,0,16'h0000);
      checkOutput(outW); checkOutput({15'b0, memReqW});

      // 6: overflow beats clear; acc_start beats ld
      applyStimulus(1,0,0,0,0,0,0,0,16'hFFFF);
      applyStimulus(0,0,1,0,0,0,0,0,16'h0000);
      applyStimulus(1,0,0,0,0,0,0,0,16'hFFFF);
      pushExp("ld_keeps_ovf", 16'h1);
      checkOutput({15'b0, ovfW});
      pushExp("set_beats_clr", 16'h1);
      applyStimulus(0,0,1,0,0,0,0,1,16'h0000);
      checkOutput({15'b0, ovfW});
      applyStimulus(1,0,0,0,0,0,0,1,16'h0055);
      pushExp("ld_no_ovf", 16'h0);
      checkOutput({15'b0, ovfW});
      pushExp("acc_ld_out", 16'h0055); pushExp("acc_ld_addr", 16'h0055);
      applyStimulus(1,0,0,0,1,0,0,0,16'h7777);
      checkOutput(outW); checkOutput(memAddrW);
      pushExp("nopi_out", 16'h0055);  pushExp("nopi_req", 16'h0);
      applyStimulus(0,0,0,0,0,0,1,0,16'h0000);
      checkOutput(outW); checkOutput({15'b0, memReqW});

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
